// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: hex glyph table and segment bit positions.
package seg7_pkg;

  // Segment bit positions within the 7-bit {a,b,c,d,e,f,g} vector
  localparam int unsigned SEG_A = 6;
  localparam int unsigned SEG_B = 5;
  localparam int unsigned SEG_C = 4;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 2;
  localparam int unsigned SEG_F = 1;
  localparam int unsigned SEG_G = 0;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Active-high glyphs, entry [n] is hex digit n (listed F down to 0)
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h7B, 7'h7F,
    7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-high seven-segment glyph lookup.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_TABLE[nibble_i];
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver with double-buffered capture and dead-time between digits.
// Optional leading-zero blanking is enabled by defining SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned N_DIGITS       = 4,
  parameter int unsigned REFRESH_DIV    = 50000,
  parameter int unsigned DEAD_CYCLES    = 2,
  parameter bit          SEG_ACTIVE_LOW = 1'b0,
  parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   blank_in,
  input  logic                  load,
  input  logic                  enable,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   dig_sel,
  output logic                  frame_tick
);

  localparam int unsigned PrescW = $clog2(REFRESH_DIV);
  localparam int unsigned IdxW   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [PrescW-1:0]     presc_q, presc_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic                  tick_q, tick_d;
  logic [4*N_DIGITS-1:0] pend_val_q, act_val_q, val_eff;
  logic [N_DIGITS-1:0]   pend_dp_q, act_dp_q, dp_eff;
  logic [N_DIGITS-1:0]   pend_blank_q, act_blank_q, blank_eff;
  logic [N_DIGITS-1:0]   auto_blank;
  logic [6:0]            seg_q, seg_d, seg_dec;
  logic                  dp_q, dp_d;
  logic [N_DIGITS-1:0]   dig_q, dig_d;
  logic [3:0]            nib;
  logic                  wrap, last_digit;

  assign wrap       = (presc_q == PrescW'(REFRESH_DIV - 1));
  assign last_digit = (idx_q == IdxW'(N_DIGITS - 1));

  always_comb begin
    presc_d = presc_q;
    idx_d   = idx_q;
    if (enable) begin
      if (wrap) begin
        presc_d = '0;
        idx_d   = last_digit ? '0 : idx_q + 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
    tick_d = enable & wrap & last_digit;
  end

  // The frame_tick cycle is the commit: that frame already displays the committed data,
  // and a load on the same cycle bypasses the pending buffer.
  always_comb begin
    val_eff   = act_val_q;
    dp_eff    = act_dp_q;
    blank_eff = act_blank_q;
    if (tick_q) begin
      val_eff   = load ? value    : pend_val_q;
      dp_eff    = load ? dp_in    : pend_dp_q;
      blank_eff = load ? blank_in : pend_blank_q;
    end
  end

  always_comb begin
    auto_blank = '0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    begin : g_lz
      logic zero_run;
      zero_run = 1'b1;
      for (int i = int'(N_DIGITS) - 1; i > 0; i--) begin
        zero_run      = zero_run & (val_eff[i*4 +: 4] == 4'h0);
        auto_blank[i] = zero_run;
      end
    end
`endif
  end

  seg7_hex_decode u_dec (
    .nibble_i (nib),
    .seg_o    (seg_dec)
  );

  always_comb begin
    logic dp_sel, blank_sel, auto_sel;
    logic [6:0] seg_raw;
    logic dp_raw;
    logic [N_DIGITS-1:0] dig_raw;
    nib       = 4'h0;
    dp_sel    = 1'b0;
    blank_sel = 1'b0;
    auto_sel  = 1'b0;
    dig_raw   = '0;
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      if (idx_q == IdxW'(i)) begin
        nib       = val_eff[i*4 +: 4];
        dp_sel    = dp_eff[i];
        blank_sel = blank_eff[i];
        auto_sel  = auto_blank[i];
        if (presc_q >= PrescW'(DEAD_CYCLES)) dig_raw[i] = 1'b1;
      end
    end
    // Auto-blanked digits keep their decimal point; force-blanked ones do not
    seg_raw = (blank_sel | auto_sel) ? SEG_BLANK : seg_dec;
    dp_raw  = dp_sel & ~blank_sel;
    if (!enable) begin
      seg_raw = SEG_BLANK;
      dp_raw  = 1'b0;
      dig_raw = '0;
    end
    seg_d = seg_raw ^ {7{SEG_ACTIVE_LOW}};
    dp_d  = dp_raw ^ SEG_ACTIVE_LOW;
    dig_d = dig_raw ^ {N_DIGITS{DIG_ACTIVE_LOW}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q      <= '0;
      idx_q        <= '0;
      tick_q       <= 1'b0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '0;
      act_val_q    <= '0;
      act_dp_q     <= '0;
      act_blank_q  <= '0;
      seg_q        <= {7{SEG_ACTIVE_LOW}};
      dp_q         <= SEG_ACTIVE_LOW;
      dig_q        <= {N_DIGITS{DIG_ACTIVE_LOW}};
    end else begin
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      tick_q      <= tick_d;
      act_val_q   <= val_eff;
      act_dp_q    <= dp_eff;
      act_blank_q <= blank_eff;
      if (load) begin
        pend_val_q   <= value;
        pend_dp_q    <= dp_in;
        pend_blank_q <= blank_in;
      end
      seg_q <= seg_d;
      dp_q  <= dp_d;
      dig_q <= dig_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign dig_sel    = dig_q;
  assign frame_tick = tick_q;

endmodule
